// File: rtl/apb_master.sv
// APB initiator: turns a valid/ready command port into APB SETUP/ACCESS phases
// and returns read data or a timeout error on a one-cycle response strobe.
module apb_master #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PSELx,
    output logic                  PENABLE,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA
);

    // Counter must be able to hold TIMEOUT itself; with TIMEOUT=0 it just wraps.
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } state_t;

    state_t                  state, state_nx;
    logic [CNT_W-1:0]        wait_cnt, cnt_nx;
    logic [ADDR_WIDTH-1:0]   addr_nx;
    logic [DATA_WIDTH-1:0]   wdata_nx, rdata_nx;
    logic                    write_nx, sel_nx, en_nx, rsp_valid_nx, rsp_err_nx;

    assign cmd_ready = (state == S_IDLE);

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_nx     = state;
        cnt_nx       = wait_cnt;
        addr_nx      = PADDR;
        write_nx     = PWRITE;
        wdata_nx     = PWDATA;
        sel_nx       = 1'b0;
        en_nx        = 1'b0;
        rsp_valid_nx = 1'b0;
        rsp_err_nx   = 1'b0;
        rdata_nx     = '0;

        unique case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_nx  = cmd_addr;
                    write_nx = cmd_write;
                    wdata_nx = cmd_wdata;
                    cnt_nx   = '0;
                    sel_nx   = 1'b1;
                    state_nx = S_SETUP;
                end
            end
            S_SETUP: begin
                sel_nx   = 1'b1;
                en_nx    = 1'b1;
                state_nx = S_ACCESS;
            end
            S_ACCESS: begin
                if (PREADY) begin
                    rsp_valid_nx = 1'b1;
                    rdata_nx     = PWRITE ? '0 : PRDATA;
                    state_nx     = S_IDLE;
                end else begin
                    cnt_nx = wait_cnt + 1'b1;
                    // wait_cnt holds the number of low samples before this one.
                    if (TIMEOUT != 0 && wait_cnt == TO_LAST) begin
                        rsp_valid_nx = 1'b1;
                        rsp_err_nx   = 1'b1;
                        state_nx     = S_IDLE;
                    end else begin
                        sel_nx = 1'b1;
                        en_nx  = 1'b1;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (PRESET) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            PSELx     <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nx;
            wait_cnt  <= cnt_nx;
            PADDR     <= addr_nx;
            PWRITE    <= write_nx;
            PWDATA    <= wdata_nx;
            PSELx     <= sel_nx;
            PENABLE   <= en_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_err   <= rsp_err_nx;
            rsp_rdata <= rdata_nx;
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed table, corner sequences and
// randomized transfers checked cycle by cycle against a transfer-level model.
module tb_apb_master;

    localparam int unsigned T = 4;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PWRITE, PSELx, PENABLE, PREADY;

    int checks = 0;
    int errors = 0;

    always #5 PCLK = ~PCLK;

    apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(T)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PSELx(PSELx), .PENABLE(PENABLE), .PREADY(PREADY), .PRDATA(PRDATA)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int unsigned wait_n;     // ACCESS samples with PREADY low before it goes high
        logic [31:0] prdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transfer-level model: a slave that stays low for w samples needs w+1
    // ACCESS cycles, unless the timeout cuts it off after T samples.
    function automatic int unsigned access_cycles(input int unsigned w);
        return (w < T) ? w + 1 : T;
    endfunction

    function automatic vec_t model(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                                   input int unsigned w, input logic [31:0] rd);
        vec_t v;
        v.write     = wr;
        v.addr      = a;
        v.wdata     = wd;
        v.wait_n    = w;
        v.prdata    = rd;
        v.exp_err   = (w >= T);
        v.exp_rdata = (!wr && w < T) ? rd : 32'h0;
        return v;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_psel"}, PSELx, 1'b0);
        check({tag, "_penable"}, PENABLE, 1'b0);
        check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    endtask

    // Entered at a negedge of an IDLE cycle; returns at the negedge of the response cycle.
    task automatic do_xfer(input vec_t v, input logic hold);
        int unsigned n_acc;
        n_acc = access_cycles(v.wait_n);
        check("cmd_ready_before", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        PREADY    = 1'($urandom_range(0, 1));
        PRDATA    = $urandom;

        @(negedge PCLK);
        // SETUP: command inputs now carry junk that must be ignored
        cmd_valid = hold;
        cmd_write = ~v.write;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        PREADY    = 1'($urandom_range(0, 1));
        PRDATA    = $urandom;
        check("setup_psel", PSELx, 1'b1);
        check("setup_penable", PENABLE, 1'b0);
        check("setup_paddr", PADDR, v.addr);
        check("setup_pwrite", PWRITE, v.write);
        check("setup_pwdata", PWDATA, v.wdata);
        check("setup_cmd_ready", cmd_ready, 1'b0);
        check("setup_rsp_valid", rsp_valid, 1'b0);

        for (int unsigned k = 0; k < n_acc; k++) begin
            @(negedge PCLK);
            check("access_psel", PSELx, 1'b1);
            check("access_penable", PENABLE, 1'b1);
            check("access_paddr", PADDR, v.addr);
            check("access_pwrite", PWRITE, v.write);
            check("access_pwdata", PWDATA, v.wdata);
            check("access_rsp_valid", rsp_valid, 1'b0);
            PREADY = (k == v.wait_n);
            PRDATA = PREADY ? v.prdata : $urandom;
        end

        @(negedge PCLK);
        PREADY = 1'($urandom_range(0, 1));
        PRDATA = $urandom;
        check("rsp_valid", rsp_valid, 1'b1);
        check("rsp_err", rsp_err, v.exp_err);
        check("rsp_rdata", rsp_rdata, v.exp_rdata);
        check("rsp_psel", PSELx, 1'b0);
        check("rsp_penable", PENABLE, 1'b0);
        check("rsp_cmd_ready", cmd_ready, 1'b1);
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge PCLK);
            check_idle_outputs("idle");
        end
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 0,   32'h0,        1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h20, 32'h0,        2,   32'h12345678, 1'b0, 32'h12345678};
        vecs[2] = '{1'b0, 32'h24, 32'h0,        100, 32'hAAAA5555, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 32'h28, 32'h0,        3,   32'hCAFEF00D, 1'b0, 32'hCAFEF00D};
        vecs[4] = '{1'b1, 32'h2C, 32'h01020304, 4,   32'hFFFFFFFF, 1'b1, 32'h0};

        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        PREADY    = 1'b0;
        PRDATA    = '0;

        repeat (2) @(negedge PCLK);
        check("reset_psel", PSELx, 1'b0);
        check("reset_penable", PENABLE, 1'b0);
        check("reset_paddr", PADDR, 32'h0);
        check("reset_pwrite", PWRITE, 1'b0);
        check("reset_pwdata", PWDATA, 32'h0);
        check("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 34'h0);
        PRESET = 1'b0;
        @(negedge PCLK);
        check_idle_outputs("post_reset");

        foreach (vecs[i]) begin
            do_xfer(vecs[i], 1'b0);
            idle_cycles(1);
        end

        // Back-to-back writes with cmd_valid held high across transfers
        do_xfer(model(1'b1, 32'h0, 32'h11111111, 0, 32'h0), 1'b1);
        do_xfer(model(1'b1, 32'h4, 32'h22222222, 0, 32'h0), 1'b1);
        do_xfer(model(1'b1, 32'h8, 32'h33333333, 0, 32'h0), 1'b0);
        idle_cycles(2);

        // Reset during the ACCESS phase of a read
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h30;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        PREADY    = 1'b0;
        @(negedge PCLK);
        check("pre_reset_penable", PENABLE, 1'b1);
        PRESET = 1'b1;
        @(negedge PCLK);
        check("midrst_sel_en", {PSELx, PENABLE}, 2'b00);
        check("midrst_paddr", PADDR, 32'h0);
        check("midrst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 34'h0);
        PRESET = 1'b0;
        idle_cycles(2);
        do_xfer(model(1'b0, 32'h34, 32'h0, 1, 32'h5A5A0F0F), 1'b0);
        idle_cycles(1);

        // Randomized transfers against the model
        for (int i = 0; i < 40; i++) begin
            vec_t v;
            logic hold;
            v = model(1'($urandom_range(0, 1)), $urandom, $urandom,
                      $urandom_range(0, 6), $urandom);
            hold = (i < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
            do_xfer(v, hold);
            if (!hold) idle_cycles($urandom_range(0, 2));
        end
        idle_cycles(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit after %0d checks", checks);
        $fatal(1);
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB initiator; the requester end of the APB bus that the APB_Wrapper slave responds on.
- Converts a simple valid/ready command port (one read or write per command) into APB SETUP/ACCESS phases on PSELx/PENABLE.
- Returns read data or a timeout error on a one-cycle response strobe.
- Used as the bus driver in system-level benches and as the future on-chip master of the wrapper.

Parameters:
- ADDR_WIDTH, 32, width of PADDR and cmd_addr
- DATA_WIDTH, 32, width of PWDATA/PRDATA/cmd_wdata/rsp_rdata
- TIMEOUT, 16, max ACCESS cycles with PREADY low before abort; 0 disables timeout (waits forever)

Ports:
- PCLK  in  1  clock, all logic on rising edge
- PRESET  in  1  synchronous reset, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  master can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  transfer address
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle completion strobe
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errors)
- rsp_err  out  1  transfer aborted by timeout (valid with rsp_valid)
- PADDR  out  ADDR_WIDTH  APB address
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_WIDTH  APB write data
- PSELx  out  1  APB slave select
- PENABLE  out  1  APB enable
- PREADY  in  1  slave ready
- PRDATA  in  DATA_WIDTH  slave read data

Behaviour:
- Interface decision: one clock (PCLK); reset PRESET is synchronous and active-high.
- Reset (PRESET=1 at an edge): state IDLE.
  - All outputs 0: PSELx, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_err, rsp_rdata, wait counter.
  - cmd_ready=1 from the first cycle after reset releases.
- All outputs are registered, with no combinational path from inputs to outputs. cmd_ready is decoded from state (1 only in IDLE).
- FSM IDLE:
  - Outputs: PSELx=0, PENABLE=0.
  - On an edge with cmd_valid && cmd_ready: latch cmd_write/addr/wdata into PWRITE/PADDR/PWDATA, then go to SETUP.
  - When idle, PADDR/PWRITE/PWDATA keep their last values.
- FSM SETUP:
  - Outputs: PSELx=1, PENABLE=0.
  - Unconditionally go to ACCESS at the next edge.
- FSM ACCESS:
  - Outputs: PSELx=1, PENABLE=1.
  - PADDR/PWRITE/PWDATA stay stable for every cycle of ACCESS.
  - At each edge, PREADY is sampled:
    - PREADY=1: capture PRDATA into rsp_rdata (reads) or 0 (writes); rsp_valid=1, rsp_err=0 in the next cycle; go to IDLE.
    - PREADY=0: wait counter increments. If TIMEOUT!=0 and the counter reaches TIMEOUT, abort: rsp_valid=1, rsp_err=1, rsp_rdata=0, go to IDLE.
  - The counter clears on entry to SETUP.
- Latency, zero wait states:
  - cmd accepted at edge N, so SETUP runs during cycle N+1 and ACCESS during N+2.
  - PREADY is sampled at edge N+2, so rsp_valid is high during N+3.
  - Minimum 3 cycles per transfer.
- rsp_valid is high exactly one cycle; there is no response back-pressure. cmd_ready is 1 in the same cycle as rsp_valid.
- Back-to-back: if cmd_valid is held high, the next command is accepted at the edge ending the rsp_valid cycle. There is always exactly one IDLE cycle (PSELx=0) between transfers.
- PREADY/PRDATA are ignored outside ACCESS.
- cmd_* are ignored outside IDLE; commands are not queued.
- Mid-transfer reset: the next edge returns to IDLE with all outputs 0 and no rsp_valid for the aborted transfer.
- Timeout boundary: with TIMEOUT=T, a transfer with PREADY low for T consecutive ACCESS samples errors. PREADY high on sample T (i.e. T-1 wait states) completes normally.

Test Plan:
- Write 0xDEADBEEF to 0x10, PREADY tied 1: PSELx high for 2 cycles, PENABLE high for 1, PADDR=0x10, PWRITE=1, PWDATA=0xDEADBEEF; rsp_valid one cycle later with rsp_err=0, rsp_rdata=0.
- Read 0x20, PREADY low for 2 ACCESS cycles, then 1 with PRDATA=0x12345678: ACCESS lasts 3 cycles with PADDR stable; rsp_rdata=0x12345678, rsp_err=0.
- TIMEOUT=4, PREADY held 0: PSELx/PENABLE drop after 4 ACCESS cycles; rsp_valid=1, rsp_err=1, rsp_rdata=0.
- TIMEOUT=4, PREADY low 3 cycles then high: normal completion, rsp_err=0.
- cmd_valid held high for 3 writes (addr 0,4,8): three SETUP/ACCESS pairs, each separated by one IDLE cycle; 3 rsp_valid pulses, 3 cycles apart.
- PRESET asserted during ACCESS of a read: next cycle PSELx=PENABLE=0, all outputs 0, no rsp_valid; a subsequent read completes normally.
